attn_head_scheduler: RTL

//  Sequences the spike-accumulation attention engine over all heads and key tiles of one layer.

---
 rtl/attn_head_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/attn_head_scheduler.sv
// Job sequencer for the spike-accumulation attention engine: walks every (head, key tile)
// of a layer, gates each launch on memory readiness and guards each job with a watchdog.
module attn_head_scheduler #(
  parameter int HEAD_NUM          = 12,
  parameter int K_TILES           = 4,
  parameter int SYSTOLIC_UNIT_NUM = 16,
  parameter int ADDR_W            = 10,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_qkv_ready,
  input  logic              i_attn_ready,
  output logic              o_job_start,
  output logic [3:0]        o_head_idx,
  output logic [1:0]        o_ktile_idx,
  output logic [ADDR_W-1:0] o_query_baseaddr,
  output logic [ADDR_W-1:0] o_key_baseaddr,
  input  logic              i_job_done,
  output logic              o_head_done,
  output logic              o_layer_done,
  output logic              o_busy,
  output logic              o_error
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AW2  = ADDR_W + 2;
  localparam logic [3:0]      HEAD_LAST  = 4'(HEAD_NUM - 1);
  localparam logic [1:0]      KTILE_LAST = 2'(K_TILES - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AW2-1:0]  Q_STRIDE   = AW2'(SYSTOLIC_UNIT_NUM);
  localparam logic [AW2-1:0]  K_STRIDE   = AW2'(HEAD_NUM * SYSTOLIC_UNIT_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RES, S_ISSUE, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        head_q, head_d;
  logic [1:0]        ktile_q, ktile_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              job_start_q, job_start_d;
  logic              head_done_q, head_done_d;
  logic              layer_done_q, layer_done_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] qaddr_q, qaddr_d;
  logic [ADDR_W-1:0] kaddr_q, kaddr_d;
  logic [AW2-1:0]    qaddr_full, kaddr_full;
  logic [1:0]        qaddr_hi_unused, kaddr_hi_unused;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    ktile_d = ktile_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_WAIT_RES;
        head_d  = '0;
        ktile_d = '0;
      end
      S_WAIT_RES: if (i_qkv_ready && i_attn_ready) state_d = S_ISSUE;
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      // A done arriving on the last watchdog cycle still counts as success.
      S_RUN: begin
        if (i_job_done)             state_d = S_NEXT;
        else if (wdog_q == WD_LAST) state_d = S_ERR;
        else                        wdog_d  = wdog_q + 1'b1;
      end
      S_NEXT: begin
        if (ktile_q == KTILE_LAST) begin
          ktile_d = '0;
          if (head_q == HEAD_LAST) begin
            state_d = S_DONE;
          end else begin
            head_d  = head_q + 1'b1;
            state_d = S_WAIT_RES;
          end
        end else begin
          ktile_d = ktile_q + 1'b1;
          state_d = S_WAIT_RES;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (i_clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the upcoming state, so they line up with it cycle for cycle.
  always_comb begin
    job_start_d  = (state_d == S_ISSUE);
    head_done_d  = (state_q == S_RUN) && (state_d == S_NEXT) && (ktile_q == KTILE_LAST);
    layer_done_d = (state_d == S_DONE);
    busy_d       = !(state_d inside {S_IDLE, S_ERR});
    error_d      = (state_d == S_ERR);
    qaddr_full   = {{(AW2-4){1'b0}}, head_d} * Q_STRIDE;
    kaddr_full   = qaddr_full + {{(AW2-2){1'b0}}, ktile_d} * K_STRIDE;
    {qaddr_hi_unused, qaddr_d} = qaddr_full;
    {kaddr_hi_unused, kaddr_d} = kaddr_full;
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      ktile_q      <= '0;
      wdog_q       <= '0;
      job_start_q  <= 1'b0;
      head_done_q  <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      qaddr_q      <= '0;
      kaddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      ktile_q      <= ktile_d;
      wdog_q       <= wdog_d;
      job_start_q  <= job_start_d;
      head_done_q  <= head_done_d;
      layer_done_q <= layer_done_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      qaddr_q      <= qaddr_d;
      kaddr_q      <= kaddr_d;
    end
  end

  assign o_job_start      = job_start_q;
  assign o_head_idx       = head_q;
  assign o_ktile_idx      = ktile_q;
  assign o_query_baseaddr = qaddr_q;
  assign o_key_baseaddr   = kaddr_q;
  assign o_head_done      = head_done_q;
  assign o_layer_done     = layer_done_q;
  assign o_busy           = busy_q;
  assign o_error          = error_q;

endmodule
